ifetch_stage: RTL and testbench
===============================

// Module: ifetch_stage
// PURPOSE
//  Instruction-fetch initiator for the 5-stage MIPS pipeline; it is the requesting end of the
//  instruction-memory read port. Owns the PC, drives the word index into imem, captures the
//  returned word into the IF/ID register, and applies stall, flush and redirect (beq/bne/jr)
//  from the hazard unit and the D stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  IMEM_AW    6              imem word-index width; imem_a = pc_f[IMEM_AW+1:2]
//  PROG_LAST  20             last valid program word index (used only with IFETCH_HALT_EN)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  stall_f      in   1        hold PC this cycle
//  stall_d      in   1        hold IF/ID register this cycle
//  flush_d      in   1        load a bubble into IF/ID this cycle
//  redirect     in   1        taken branch or jr resolved in D
//  redirect_pc  in   32       byte target address; bits [1:0] are ignored
//  imem_a       out  IMEM_AW  word index to imem (combinational from pc_f)
//  imem_rd      in   32       instruction word from imem (combinational read)
//  pc_f         out  32       current fetch PC
//  instr_d      out  32       IF/ID instruction
//  pc_plus4_d   out  32       IF/ID pc_f+4
//  valid_d      out  1        1 = instr_d is a real fetched instruction; 0 = bubble
//  halted       out  1        fetch is parked (IFETCH_HALT_EN only; otherwise tied to 0)
// BEHAVIOUR
//  - Reset, asynchronous: pc_f=RESET_PC, instr_d=0, pc_plus4_d=0, valid_d=0, halted=0, state=RUN.
//    Reset asserted mid-run clears all of these immediately. Fetch of RESET_PC starts in the
//    first cycle after reset is released.
//  - imem_a = pc_f[IMEM_AW+1:2]. The index is truncated: a PC of 256 or above aliases.
//  - Latency: the word at pc_f appears on instr_d after the next edge, with pc_plus4_d=pc_f+4
//    and valid_d=1.
//  - Next-PC priority: redirect > stall_f > pc_f+4.
//    * redirect: pc_f <= {redirect_pc[31:2],2'b00}. This applies even when stall_f=1.
//    * PC arithmetic is 32-bit modulo 2^32.
//  - IF/ID priority: flush_d > stall_d > load.
//    * flush_d: instr_d=0, valid_d=0, pc_plus4_d=0.
//    * stall_d: all three IF/ID outputs hold.
//    * load: instr_d=imem_rd, pc_plus4_d=pc_f+4, valid_d=1.
//  - Redirect does not flush IF/ID by itself; the hazard unit asserts flush_d in the same cycle.
//  - FSM (IFETCH_HALT_EN only), states RUN and HALT:
//    * RUN->HALT: when pc_f > PROG_LAST*4, redirect=0 and stall_f=0.
//      On that edge pc_f holds and IF/ID loads a bubble (unless stall_d). halted=1 from the next cycle.
//    * HALT: pc_f frozen; IF/ID loads a bubble each cycle (flush_d/stall_d still apply).
//    * HALT->RUN: only on redirect (a jr or branch still in flight), which loads redirect_pc.
//      halted=0 from the next cycle.
// CONFIGURATION
//  IFETCH_HALT_EN defined: the RUN/HALT FSM and the halted output are active.
//  IFETCH_HALT_EN undefined: there is no FSM and halted=0.
//    * pc_f keeps incrementing; imem returns nop beyond the program; those words are loaded
//      with valid_d=1.
// STRUCTURE
//  - mips_pkg holds:
//    * NOP_INSTR = 32'h0000_0000
//    * RESET_PC_DEFAULT
//    * typedef enum logic {FS_RUN, FS_HALT} fetch_state_t
//  - One sub-module, ifid_reg: the IF/ID register with flush/stall priority.
//  - PC mux and FSM are in ifetch_stage.
// TESTING
//  1. Reset, then release and run 5 cycles.
//     -> imem_a = 0,1,2,3,4.
//     -> First edge: instr_d=32'h2002000A, pc_plus4_d=4, valid_d=1.
//  2. At pc_f=0x14, hold stall_f=stall_d=1 for 2 cycles.
//     -> pc_f stays 0x14; instr_d holds 32'h20070050. Release -> pc_f=0x18.
//  3. redirect=1, redirect_pc=0x44 and flush_d=1 in the same cycle.
//     -> Next edge: pc_f=0x44, valid_d=0, instr_d=0.
//     -> Following edge: instr_d=32'h20420001.
//  4. redirect=1 with stall_f=1, redirect_pc=0x52.
//     -> pc_f=0x50 (redirect wins, low bits dropped).
//  5. HALT_EN: run to pc_f=0x54.
//     -> halted=1, pc_f stays 0x54, valid_d=0.
//     -> Then redirect_pc=0 -> pc_f=0, halted=0.
//     Without HALT_EN: pc_f=0x58, imem_a=22, instr_d=0, valid_d=1.
//  6. Assert reset at pc_f=0x30 with valid_d=1.
//     -> Immediately pc_f=0, valid_d=0, instr_d=0, halted=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch front end.
// Exports: NOP_INSTR (bubble encoding), RESET_PC_DEFAULT, fetch_state_t (RUN/HALT).
// No ports; imported by the fetch stage and the IF/ID register.
package mips_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory read port between the fetch stage and imem.
// Ports: imem_a (word index, driven by fetch), imem_rd (combinational read data from imem).
// Modports: master = fetch side, slave = memory side.
interface ifetch_stage_if #(
   parameter int AW = 6
);
   logic [AW-1:0] imem_a;
   logic [31:0]   imem_rd;

   modport master (output imem_a, input  imem_rd);
   modport slave  (input  imem_a, output imem_rd);
endinterface

// File: rtl/ifetch_stage_ifid_reg.sv
// IF/ID pipeline register: flush beats stall beats load; a bubble clears all three fields.
// Ports: clk/reset, flush_i, stall_i, bubble_i (load a bubble instead of the fetched word),
//        instr_i/pc_plus4_i (fetched word and its pc+4), instr_o/pc_plus4_o/valid_o (registered).
module ifid_reg
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_i,
   input  logic        stall_i,
   input  logic        bubble_i,
   input  logic [31:0] instr_i,
   input  logic [31:0] pc_plus4_i,
   output logic [31:0] instr_o,
   output logic [31:0] pc_plus4_o,
   output logic        valid_o
);

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_plus4_q, pc_plus4_d;
   logic        valid_q, valid_d;

   always_comb begin
      instr_d    = instr_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
      if (flush_i || (!stall_i && bubble_i)) begin
         instr_d    = NOP_INSTR;
         pc_plus4_d = 32'h0;
         valid_d    = 1'b0;
      end else if (!stall_i) begin
         instr_d    = instr_i;
         pc_plus4_d = pc_plus4_i;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q    <= NOP_INSTR;
         pc_plus4_q <= 32'h0;
         valid_q    <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_plus4_q <= pc_plus4_d;
         valid_q    <= valid_d;
      end
   end

   assign instr_o    = instr_q;
   assign pc_plus4_o = pc_plus4_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: owns the PC, indexes imem, fills IF/ID; redirect > stall_f > pc+4.
// Ports: clk/reset, stall_f, stall_d, flush_d, redirect/redirect_pc, imem (master port),
//        pc_f, instr_d, pc_plus4_d, valid_d, halted. Define IFETCH_HALT_EN to park fetch past PROG_LAST.
module ifetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
   parameter int          IMEM_AW   = 6,
   parameter int          PROG_LAST = 20
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall_f,
   input  logic                  stall_d,
   input  logic                  flush_d,
   input  logic                  redirect,
   input  logic [31:0]           redirect_pc,
   ifetch_stage_if.master        imem,
   output logic [31:0]           pc_f,
   output logic [31:0]           instr_d,
   output logic [31:0]           pc_plus4_d,
   output logic                  valid_d,
   output logic                  halted
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] pc_redir;
   logic        bubble;

   assign pc_plus4 = pc_q + 32'd4;
   // Byte target forced to word alignment.
   assign pc_redir = redirect_pc & 32'hFFFF_FFFC;

   // Index truncates: PCs beyond the imem window alias back into it.
   assign imem.imem_a = pc_q[IMEM_AW+1:2];

`ifdef IFETCH_HALT_EN
   localparam logic [31:0] LAST_PC = 32'(PROG_LAST * 4);

   fetch_state_t state_q;
   logic         halted_q;
   logic         past_prog;

   assign past_prog = (pc_q > LAST_PC);

   always_comb begin
      pc_d   = pc_q;
      bubble = 1'b0;
      if (state_q == FS_HALT) begin
         // Parked: only a late redirect (jr/branch still in flight) restarts fetch.
         bubble = 1'b1;
         if (redirect) pc_d = pc_redir;
      end else if (redirect) begin
         pc_d = pc_redir;
      end else if (stall_f) begin
         pc_d = pc_q;
      end else if (past_prog) begin
         // Entering HALT: hold the PC and stop feeding garbage into decode.
         bubble = 1'b1;
      end else begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= FS_RUN;
         halted_q <= 1'b0;
      end else begin
         case (state_q)
            FS_RUN: begin
               if (!redirect && !stall_f && past_prog) begin
                  state_q  <= FS_HALT;
                  halted_q <= 1'b1;
               end
            end
            FS_HALT: begin
               if (redirect) begin
                  state_q  <= FS_RUN;
                  halted_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= FS_RUN;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign halted = halted_q;
`else
   always_comb begin
      bubble = 1'b0;
      if (redirect)     pc_d = pc_redir;
      else if (stall_f) pc_d = pc_q;
      else              pc_d = pc_plus4;
   end

   assign halted = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= RESET_PC;
      else       pc_q <= pc_d;
   end

   assign pc_f = pc_q;

   ifid_reg u_ifid (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (flush_d),
      .stall_i    (stall_d),
      .bubble_i   (bubble),
      .instr_i    (imem.imem_rd),
      .pc_plus4_i (pc_plus4),
      .instr_o    (instr_d),
      .pc_plus4_o (pc_plus4_d),
      .valid_o    (valid_d)
   );

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios then randomized control inputs.
// Ports: none; drives the fetch stage and models imem plus a behavioural fetch reference.
// Honours IFETCH_HALT_EN in the reference model.
module tb_ifetch_stage;
   import mips_pkg::*;

   localparam int PROG_LAST = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_f, stall_d, flush_d, redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_f, instr_d, pc_plus4_d;
   logic        valid_d, halted;

   logic [31:0] mem [64];

   ifetch_stage_if #(.AW(6)) imem_bus ();
   assign imem_bus.imem_rd = mem[imem_bus.imem_a];

   ifetch_stage #(.RESET_PC(32'h0), .IMEM_AW(6), .PROG_LAST(PROG_LAST)) dut (
      .clk         (clk),
      .reset       (reset),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .flush_d     (flush_d),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem        (imem_bus),
      .pc_f        (pc_f),
      .instr_d     (instr_d),
      .pc_plus4_d  (pc_plus4_d),
      .valid_d     (valid_d),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference state
   logic [31:0] m_pc, m_instr, m_pp4;
   bit          m_valid, m_halt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 0; m_halt = 0;
   endtask

   // One clock edge of the reference: fetch the word at the current PC, then advance.
   task automatic m_step(input bit sf, input bit sd, input bit fl, input bit rd,
                         input logic [31:0] rpc);
      logic [31:0] target, fetched, next_pc;
      bit          give_bubble, next_halt;
      target      = (rpc / 4) * 4;
      fetched     = mem[(m_pc / 4) % 64];
      next_pc     = m_pc;
      next_halt   = m_halt;
      give_bubble = 0;
`ifdef IFETCH_HALT_EN
      if (m_halt) begin
         give_bubble = 1;
         if (rd) begin next_pc = target; next_halt = 0; end
      end else if (rd) next_pc = target;
      else if (sf) next_pc = m_pc;
      else if (m_pc > PROG_LAST * 4) begin give_bubble = 1; next_halt = 1; end
      else next_pc = m_pc + 4;
`else
      if (rd)      next_pc = target;
      else if (sf) next_pc = m_pc;
      else         next_pc = m_pc + 4;
`endif
      if (fl || (!sd && give_bubble)) begin
         m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 0;
      end else if (!sd) begin
         m_instr = fetched; m_pp4 = m_pc + 4; m_valid = 1;
      end
      m_pc   = next_pc;
      m_halt = next_halt;
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, ".pc_f"},       pc_f,       m_pc);
      chk({tag, ".imem_a"},     {26'h0, imem_bus.imem_a}, (m_pc / 4) % 64);
      chk({tag, ".instr_d"},    instr_d,    m_instr);
      chk({tag, ".pc_plus4_d"}, pc_plus4_d, m_pp4);
      chk({tag, ".valid_d"},    {31'h0, valid_d}, {31'h0, m_valid});
      chk({tag, ".halted"},     {31'h0, halted},  {31'h0, m_halt});
   endtask

   task automatic cyc(input string tag, input bit sf, input bit sd, input bit fl, input bit rd,
                      input logic [31:0] rpc);
      stall_f = sf; stall_d = sd; flush_d = fl; redirect = rd; redirect_pc = rpc;
      @(posedge clk);
      m_step(sf, sd, fl, rd, rpc);
      #1;
      cmp_all(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) cyc(tag, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = (i <= PROG_LAST) ? ($urandom | 32'h1) : 32'h0;
      mem[0]  = 32'h2002000A;
      mem[4]  = 32'h20070050;
      mem[17] = 32'h20420001;

      reset = 1; stall_f = 0; stall_d = 0; flush_d = 0; redirect = 0; redirect_pc = 0;
      m_reset();
      #12;
      cmp_all("reset");
      reset = 0;
      #1;
      chk("t1.imem_a0", {26'h0, imem_bus.imem_a}, 32'd0);

      // 1: plain sequential fetch
      for (int k = 1; k <= 5; k++) begin
         cyc("t1", 0, 0, 0, 0, 32'h0);
         if (k <= 4) chk("t1.imem_a", {26'h0, imem_bus.imem_a}, k);
         if (k == 1) begin
            chk("t1.first_instr", instr_d, 32'h2002000A);
            chk("t1.first_pp4", pc_plus4_d, 32'd4);
            chk("t1.first_valid", {31'h0, valid_d}, 32'd1);
         end
      end
      chk("t2.pc_start", pc_f, 32'h14);

      // 2: stall both stages
      for (int k = 0; k < 2; k++) begin
         cyc("t2", 1, 1, 0, 0, 32'h0);
         chk("t2.pc_hold", pc_f, 32'h14);
         chk("t2.instr_hold", instr_d, 32'h20070050);
      end
      cyc("t2r", 0, 0, 0, 0, 32'h0);
      chk("t2.pc_release", pc_f, 32'h18);

      // 3: redirect with flush
      cyc("t3", 0, 0, 1, 1, 32'h44);
      chk("t3.pc", pc_f, 32'h44);
      chk("t3.valid", {31'h0, valid_d}, 32'd0);
      chk("t3.instr", instr_d, 32'h0);
      cyc("t3b", 0, 0, 0, 0, 32'h0);
      chk("t3.target_instr", instr_d, 32'h20420001);

      // 4: redirect beats stall_f, low bits dropped
      cyc("t4", 1, 0, 0, 1, 32'h52);
      chk("t4.pc", pc_f, 32'h50);

      // 5: run off the end of the program
      cyc("t5a", 0, 0, 0, 0, 32'h0);
      chk("t5.pc54", pc_f, 32'h54);
      cyc("t5b", 0, 0, 0, 0, 32'h0);
`ifdef IFETCH_HALT_EN
      chk("t5.halted", {31'h0, halted}, 32'd1);
      chk("t5.pc_park", pc_f, 32'h54);
      chk("t5.valid", {31'h0, valid_d}, 32'd0);
      cyc("t5c", 0, 0, 0, 0, 32'h0);
      chk("t5.pc_still", pc_f, 32'h54);
`else
      chk("t5.pc", pc_f, 32'h58);
      chk("t5.imem_a", {26'h0, imem_bus.imem_a}, 32'd22);
      chk("t5.instr", instr_d, 32'h0);
      chk("t5.valid", {31'h0, valid_d}, 32'd1);
`endif
      cyc("t5d", 0, 0, 0, 1, 32'h0);
      chk("t5.pc_restart", pc_f, 32'h0);
      chk("t5.unhalted", {31'h0, halted}, 32'd0);

      // 6: asynchronous reset mid-run
      run("t6", 12);
      chk("t6.pc30", pc_f, 32'h30);
      chk("t6.valid_pre", {31'h0, valid_d}, 32'd1);
      #3 reset = 1;
      #1;
      m_reset();
      chk("t6.pc", pc_f, 32'h0);
      chk("t6.valid", {31'h0, valid_d}, 32'd0);
      chk("t6.instr", instr_d, 32'h0);
      chk("t6.halted", {31'h0, halted}, 32'd0);
      @(posedge clk);
      #2 reset = 0;
      #1 cmp_all("t6.release");

      // Randomized control traffic
      for (int n = 0; n < 400; n++) begin
         bit sf, sd, fl, rd;
         logic [31:0] rpc;
         sf  = ($urandom_range(0, 4) == 0);
         sd  = ($urandom_range(0, 4) == 0);
         fl  = ($urandom_range(0, 5) == 0);
         rd  = ($urandom_range(0, 7) == 0);
         rpc = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 127);
         cyc("rnd", sf, sd, fl, rd, rpc);
         if ($urandom_range(0, 59) == 0) begin
            #2 reset = 1;
            #1;
            m_reset();
            cmp_all("rnd.reset");
            @(posedge clk);
            #2 reset = 0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
